// File: rtl/byte_serial_add_seq_if.sv
// byte_serial_add_seq_if
//   Bundles every signal of the byte-serial add sequencer except clk/rst:
//   the operand byte stream, the link to the external 8-bit ripple adder,
//   and the result stream.
//   slave  : sequencer side (drives in_ready, adder inputs, result)
//   master : environment side (drives operand bytes, adder outputs, out_ready)
//   Optional: SIGNED_OVF_EN adds out_ovf (two's-complement overflow flag).
interface byte_serial_add_seq_if #(
  parameter int NBYTES = 4
);
  logic                  op_cin;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic [7:0]            in_a;
  logic [7:0]            in_b;
  logic [7:0]            adder_a;
  logic [7:0]            adder_b;
  logic                  adder_cin;
  logic [7:0]            adder_sum;
  logic                  adder_cout;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_sum;
  logic                  out_cout;
  logic                  err_restart;
`ifdef SIGNED_OVF_EN
  logic                  out_ovf;
`endif

  modport slave (
    input  op_cin, in_valid, in_first, in_a, in_b, adder_sum, adder_cout, out_ready,
    output in_ready, adder_a, adder_b, adder_cin, out_valid, out_sum, out_cout, err_restart
`ifdef SIGNED_OVF_EN
    , output out_ovf
`endif
  );

  modport master (
    output op_cin, in_valid, in_first, in_a, in_b, adder_sum, adder_cout, out_ready,
    input  in_ready, adder_a, adder_b, adder_cin, out_valid, out_sum, out_cout, err_restart
`ifdef SIGNED_OVF_EN
    , input out_ovf
`endif
  );
endinterface

// File: rtl/byte_serial_add_seq.sv
// byte_serial_add_seq
//   Feeds an external combinational 8-bit adder one operand byte pair per
//   handshake (LSB first), chains the carry between bytes, collects the sum
//   bytes and presents the NBYTES-wide result with the final carry-out.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - byte_serial_add_seq_if.slave: operand stream (op_cin, in_valid,
//          in_ready, in_first, in_a, in_b), adder link (adder_a/b/cin,
//          adder_sum/cout), result stream (out_valid, out_ready, out_sum,
//          out_cout) and err_restart pulse.
// Optional: define SIGNED_OVF_EN to add bus.out_ovf.
//
// state | meaning
// IDLE  | no byte of the current operation taken yet
// RUN   | 1..NBYTES-1 bytes taken
// DONE  | result held until out_ready
module byte_serial_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  byte_serial_add_seq_if.slave bus
);
  localparam int IDXW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [8*NBYTES-1:0] sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
`ifdef SIGNED_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  logic                restart;
  logic [IDXW-1:0]     eff_idx;
  logic                accept;

  // A byte taken in IDLE, or a re-flagged first byte in RUN, always lands
  // at position 0 and uses op_cin.
  assign restart = (state_q == RUN) && bus.in_first;
  assign eff_idx = ((state_q == IDLE) || restart) ? '0 : idx_q;

  assign bus.in_ready  = (state_q != DONE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.adder_a   = bus.in_a;
  assign bus.adder_b   = bus.in_b;
  assign bus.adder_cin = (eff_idx == '0) ? bus.op_cin : carry_q;

  assign bus.out_valid   = valid_q;
  assign bus.out_sum     = sum_q;
  assign bus.out_cout    = cout_q;
  assign bus.err_restart = err_q;
`ifdef SIGNED_OVF_EN
  assign bus.out_ovf     = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    err_d   = 1'b0;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (eff_idx == IDXW'(i)) sum_d[8*i +: 8] = bus.adder_sum;
          end
          carry_d = bus.adder_cout;
          err_d   = restart;
          if (eff_idx == IDXW'(NBYTES-1)) begin
            cout_d  = bus.adder_cout;
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = DONE;
`ifdef SIGNED_OVF_EN
            ovf_d   = (bus.in_a[7] ~^ bus.in_b[7]) & (bus.adder_sum[7] ^ bus.in_a[7]);
`endif
          end else begin
            idx_d   = eff_idx + IDXW'(1);
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_byte_serial_add_seq.sv
// tb_byte_serial_add_seq
//   Directed bench for byte_serial_add_seq (NBYTES=4) with a behavioural
//   8-bit adder closing the loop. Define SIGNED_OVF_EN to cover out_ovf.
module tb_byte_serial_add_seq;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   err_seen = 0;

  always #5 clk = ~clk;

  byte_serial_add_seq_if #(.NBYTES(NB)) bus ();

  byte_serial_add_seq #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // external ripple adder stand-in
  logic [8:0] add_res;
  assign add_res = {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {8'd0, bus.adder_cin};
  assign bus.adder_sum  = add_res[7:0];
  assign bus.adder_cout = add_res[8];

  // Drives one byte pair for one cycle starting at posedge+1; returns at next posedge+1.
  task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input logic first,
                           input logic cin, input logic exp_cin, input string name);
    bus.in_a = a; bus.in_b = b; bus.in_first = first; bus.op_cin = cin; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready: got %b want 1", name, bus.in_ready);
    end
    checks++;
    if (bus.adder_a !== a || bus.adder_b !== b) begin
      errors++; $display("FAIL %s adder_ab: got %h/%h want %h/%h", name, bus.adder_a, bus.adder_b, a, b);
    end
    checks++;
    if (bus.adder_cin !== exp_cin) begin
      errors++; $display("FAIL %s adder_cin: got %b want %b", name, bus.adder_cin, exp_cin);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    if (bus.err_restart === 1'b1) err_seen++;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (bus.err_restart === 1'b1) err_seen++;
    end
  endtask

  // Full operation, in_first on byte 0, op_cin deliberately inverted on later bytes.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input int gap, input string name);
    logic       c;
    logic [8:0] t;
    c = cin;
    for (int i = 0; i < NB; i++) begin
      send_byte(a[8*i +: 8], b[8*i +: 8], i == 0, (i == 0) ? cin : ~cin, c, name);
      t = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'd0, c};
      c = t[8];
      if (i != NB-1) idle_cycles(gap);
    end
  endtask

  task automatic take_result(input logic [31:0] exp_sum, input logic exp_cout, input string name);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL %s out_valid timeout: got %b want 1", name, bus.out_valid);
    end
    checks++;
    if (bus.out_sum !== exp_sum) begin
      errors++; $display("FAIL %s out_sum: got %h want %h", name, bus.out_sum, exp_sum);
    end
    checks++;
    if (bus.out_cout !== exp_cout) begin
      errors++; $display("FAIL %s out_cout: got %b want %b", name, bus.out_cout, exp_cout);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release: got valid=%b ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.err_restart !== 1'b0) begin
      errors++; $display("FAIL reset ctl: got ready=%b valid=%b err=%b want 0/0/0",
                         bus.in_ready, bus.out_valid, bus.err_restart);
    end
    checks++;
    if (bus.out_sum !== 32'h0 || bus.out_cout !== 1'b0) begin
      errors++; $display("FAIL reset data: got %h/%b want 0/0", bus.out_sum, bus.out_cout);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple;
    send_op(32'h000000FF, 32'h00000001, 1'b0, 0, "ripple");
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL ripple latency: got out_valid=%b want 1", bus.out_valid);
    end
    take_result(32'h00000100, 1'b0, "ripple");
  endtask

  task automatic test_all_ones;
    send_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, "ones");
    take_result(32'h00000000, 1'b1, "ones");
  endtask

  task automatic test_gapped;
    err_seen = 0;
    send_op(32'h0A0A0A0A, 32'h05050505, 1'b0, 2, "gapped");
    take_result(32'h0F0F0F0F, 1'b0, "gapped");
    checks++;
    if (err_seen != 0) begin
      errors++; $display("FAIL gapped err_restart: got %0d pulses want 0", err_seen);
    end
  endtask

  task automatic test_back_to_back;
    send_op(32'h12345678, 32'h11111111, 1'b0, 0, "bp");
    // offer a byte while the result is held; it must not be taken
    bus.in_a = 8'hAA; bus.in_b = 8'h55; bus.in_first = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== 32'h23456789) begin
        errors++; $display("FAIL bp hold: got ready=%b valid=%b sum=%h want 0/1/23456789",
                           bus.in_ready, bus.out_valid, bus.out_sum);
      end
    end
    bus.in_valid = 1'b0; bus.in_first = 1'b0;
    take_result(32'h23456789, 1'b0, "bp");
    send_op(32'h80000000, 32'h80000000, 1'b0, 0, "b2b");
    take_result(32'h00000000, 1'b1, "b2b");
  endtask

  task automatic test_restart;
    err_seen = 0;
    send_byte(8'h11, 8'h22, 1'b1, 1'b1, 1'b1, "rs0");
    send_byte(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, "rs1");
    send_byte(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, "rs_first");
    send_byte(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "rs_b1");
    send_byte(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "rs_b2");
    send_byte(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "rs_b3");
    checks++;
    if (err_seen != 1) begin
      errors++; $display("FAIL restart err_restart: got %0d pulses want 1", err_seen);
    end
    take_result(32'h00000002, 1'b0, "restart");
  endtask

  task automatic test_reset_mid;
    send_byte(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "mid0");
    send_byte(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, "mid1");
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_sum !== 32'h0) begin
      errors++; $display("FAIL midrst: got valid=%b ready=%b sum=%h want 0/0/0",
                         bus.out_valid, bus.in_ready, bus.out_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // idx back at 0: first byte uses op_cin even without in_first
    send_byte(8'h03, 8'h04, 1'b0, 1'b1, 1'b1, "post0");
    send_byte(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "post1");
    send_byte(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "post2");
    send_byte(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "post3");
    take_result(32'h00000008, 1'b0, "postrst");
  endtask

`ifdef SIGNED_OVF_EN
  task automatic test_ovf;
    send_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, "ovf1");
    checks++;
    if (bus.out_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf1 out_ovf: got %b want 1", bus.out_ovf);
    end
    take_result(32'h80000000, 1'b0, "ovf1");
    send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "ovf0");
    checks++;
    if (bus.out_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf0 out_ovf: got %b want 0", bus.out_ovf);
    end
    take_result(32'h00000000, 1'b1, "ovf0");
  endtask
`endif

  initial begin
    bus.op_cin = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0;
    bus.in_a = 8'h00; bus.in_b = 8'h00; bus.out_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_carry_ripple;
    test_all_ones;
    test_gapped;
    test_back_to_back;
    test_restart;
    test_reset_mid;
`ifdef SIGNED_OVF_EN
    test_ovf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
